// File: rtl/cpu_tempbank.sv
// Temporary-register bank for the 8008 datapath: DEPTH x WIDTH entries with gated read,
// raw taps, valid flags, one-cycle swap and a low-then-high byte-pair load sequencer.
module cpu_tempbank #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) (
  input  logic                          CLK_I,
  input  logic                          RST_I,
  input  logic                          CLR_I,
  input  logic                          WR_I,
  input  logic [ADDR_W-1:0]             WADDR_I,
  input  logic [WIDTH-1:0]              DAT_I,
  input  logic                          RD_I,
  input  logic [ADDR_W-1:0]             RADDR_I,
  output logic [WIDTH-1:0]              DAT_O,
  output logic [(2**ADDR_W)*WIDTH-1:0]  RAW_O,
  output logic [(2**ADDR_W)-1:0]        VALID_O,
  input  logic                          SWP_I,
  input  logic [ADDR_W-1:0]             SWPA_I,
  input  logic [ADDR_W-1:0]             SWPB_I,
  input  logic                          PLD_I,
  input  logic [ADDR_W-2:0]             PIDX_I,
  input  logic                          DSTB_I,
  output logic                          BUSY_O,
  output logic                          DONE_O,
  output logic [2*WIDTH-1:0]            PAIR_O,
  output logic [1:0]                    FSM_STATE_O
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } pair_state_t;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  valid_r;
  pair_state_t       state;
  logic [ADDR_W-2:0] pidx_r;
  logic              busy_r;
  logic              done_r;
  logic              cap_en;
  logic [ADDR_W-1:0] cap_addr;

  // The sequencer owns the single write port on a strobe cycle; WR_I loses to it.
  assign cap_en   = DSTB_I && (state != S_IDLE);
  assign cap_addr = {pidx_r, (state == S_HIGH)};

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid_r <= '0;
      state   <= S_IDLE;
      pidx_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (CLR_I) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        valid_r <= '0;
        state   <= S_IDLE;
        busy_r  <= 1'b0;
      end else if (SWP_I) begin
        if (SWPA_I != SWPB_I) begin
          mem[SWPA_I]     <= mem[SWPB_I];
          mem[SWPB_I]     <= mem[SWPA_I];
          valid_r[SWPA_I] <= valid_r[SWPB_I];
          valid_r[SWPB_I] <= valid_r[SWPA_I];
        end
      end else if (cap_en) begin
        mem[cap_addr]     <= DAT_I;
        valid_r[cap_addr] <= 1'b1;
        if (state == S_LOW) begin
          state <= S_HIGH;
        end else begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
      end else begin
        if (WR_I) begin
          mem[WADDR_I]     <= DAT_I;
          valid_r[WADDR_I] <= 1'b1;
        end
        if ((state == S_IDLE) && PLD_I) begin
          pidx_r <= PIDX_I;
          state  <= S_LOW;
          busy_r <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    RAW_O = '0;
    for (int i = 0; i < DEPTH; i++) RAW_O[i*WIDTH +: WIDTH] = mem[i];
  end

  assign DAT_O       = RD_I ? mem[RADDR_I] : '0;
  assign VALID_O     = valid_r;
  assign BUSY_O      = busy_r;
  assign DONE_O      = done_r;
  assign PAIR_O      = {mem[{pidx_r, 1'b1}], mem[{pidx_r, 1'b0}]};
  assign FSM_STATE_O = state;
endmodule

// File: tb/tb_cpu_tempbank.sv
// Bench for cpu_tempbank: directed scenarios plus random traffic, every cycle's outputs
// predicted by a behavioural bank model and compared through an expected queue.
module tb_cpu_tempbank;
  localparam int W = 8 + 32 + 4 + 1 + 1 + 16;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        CLR_I, WR_I, RD_I, SWP_I, PLD_I, DSTB_I;
  logic [1:0]  WADDR_I, RADDR_I, SWPA_I, SWPB_I;
  logic [0:0]  PIDX_I;
  logic [7:0]  DAT_I, DAT_O;
  logic [31:0] RAW_O;
  logic [3:0]  VALID_O;
  logic        BUSY_O, DONE_O;
  logic [15:0] PAIR_O;
  logic [1:0]  FSM_STATE_O;

  cpu_tempbank #(.WIDTH(8), .ADDR_W(2)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .CLR_I(CLR_I), .WR_I(WR_I), .WADDR_I(WADDR_I),
    .DAT_I(DAT_I), .RD_I(RD_I), .RADDR_I(RADDR_I), .DAT_O(DAT_O), .RAW_O(RAW_O),
    .VALID_O(VALID_O), .SWP_I(SWP_I), .SWPA_I(SWPA_I), .SWPB_I(SWPB_I),
    .PLD_I(PLD_I), .PIDX_I(PIDX_I), .DSTB_I(DSTB_I), .BUSY_O(BUSY_O),
    .DONE_O(DONE_O), .PAIR_O(PAIR_O), .FSM_STATE_O(FSM_STATE_O)
  );

  // clock / reset
  always #5 CLK_I = ~CLK_I;

  // reference model: contents, valid flags, strobes still owed to the pair load
  logic [7:0] m_ent [4];
  logic [3:0] m_val;
  int         m_pend;
  logic       m_p;
  logic       m_done;

  logic [W-1:0] exp_q [$];
  int n_vec  = 0;
  int n_miss = 0;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_ent[i] = 8'h00;
    m_val  = 4'b0000;
    m_pend = 0;
    m_p    = 1'b0;
    m_done = 1'b0;
  endfunction

  function automatic logic [W-1:0] model_outputs(input logic rd, input logic [1:0] ra);
    logic [7:0] d;
    int lo;
    d  = rd ? m_ent[ra] : 8'h00;
    lo = 2 * int'(m_p);
    return {d, m_ent[3], m_ent[2], m_ent[1], m_ent[0], m_val, (m_pend != 0), m_done,
            m_ent[lo+1], m_ent[lo]};
  endfunction

  function automatic void model_step(input logic clr, wr, input logic [1:0] wa,
                                     input logic [7:0] d, input logic swp,
                                     input logic [1:0] sa, sb, input logic pld,
                                     input logic [0:0] pidx, input logic dstb);
    logic [7:0] t8;
    logic       tv;
    int         a;
    m_done = 1'b0;
    if (clr) begin
      for (int i = 0; i < 4; i++) m_ent[i] = 8'h00;
      m_val  = 4'b0000;
      m_pend = 0;
    end else if (swp) begin
      t8 = m_ent[sa]; m_ent[sa] = m_ent[sb]; m_ent[sb] = t8;
      tv = m_val[sa]; m_val[sa] = m_val[sb]; m_val[sb] = tv;
    end else if (m_pend != 0 && dstb) begin
      a = 2 * int'(m_p) + (2 - m_pend);
      m_ent[a] = d;
      m_val[a] = 1'b1;
      m_pend--;
      if (m_pend == 0) m_done = 1'b1;
    end else begin
      if (wr) begin
        m_ent[wa] = d;
        m_val[wa] = 1'b1;
      end
      if (m_pend == 0 && pld) begin
        m_p    = pidx[0];
        m_pend = 2;
      end
    end
  endfunction

  // driver tasks
  task automatic cyc(input logic clr, wr, input logic [1:0] wa, input logic [7:0] d,
                     input logic rd, input logic [1:0] ra, input logic swp,
                     input logic [1:0] sa, sb, input logic pld, input logic [0:0] pidx,
                     input logic dstb);
    @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    CLR_I = clr; WR_I = wr; WADDR_I = wa; DAT_I = d; RD_I = rd; RADDR_I = ra;
    SWP_I = swp; SWPA_I = sa; SWPB_I = sb; PLD_I = pld; PIDX_I = pidx; DSTB_I = dstb;
    exp_q.push_back(model_outputs(rd, ra));
    model_step(clr, wr, wa, d, swp, sa, sb, pld, pidx, dstb);
  endtask

  task automatic idle(input logic rd = 1'b0, input logic [1:0] ra = 2'd0);
    cyc(0, 0, 2'd0, 8'h00, rd, ra, 0, 2'd0, 2'd0, 0, 1'b0, 0);
  endtask

  task automatic async_reset();
    @(posedge CLK_I);
    #1;
    CLR_I = 0; WR_I = 0; RD_I = 0; SWP_I = 0; PLD_I = 0; DSTB_I = 0;
    #2;
    RST_I = 1'b1;
    model_reset();
    exp_q.push_back(model_outputs(1'b0, 2'd0));
  endtask

  // scoreboard monitor
  always @(negedge CLK_I) begin
    logic [W-1:0] got, exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {DAT_O, RAW_O, VALID_O, BUSY_O, DONE_O, PAIR_O};
      n_vec++;
      if (got !== exp) begin
        n_miss++;
        $display("FAIL outputs vec %0d: got dat=%h raw=%h valid=%b busy=%b done=%b pair=%h ; expected dat=%h raw=%h valid=%b busy=%b done=%b pair=%h",
                 n_vec, got[61:54], got[53:22], got[21:18], got[17], got[16], got[15:0],
                 exp[61:54], exp[53:22], exp[21:18], exp[17], exp[16], exp[15:0]);
      end
    end
  end

  initial begin
    RST_I = 1'b1;
    CLR_I = 0; WR_I = 0; WADDR_I = 0; DAT_I = 0; RD_I = 0; RADDR_I = 0;
    SWP_I = 0; SWPA_I = 0; SWPB_I = 0; PLD_I = 0; PIDX_I = 0; DSTB_I = 0;
    model_reset();
    repeat (2) @(posedge CLK_I);

    idle(1'b1, 2'd2);
    // write then gated read
    cyc(0, 1, 2'd2, 8'hA5, 1, 2'd2, 0, 2'd0, 2'd0, 0, 1'b0, 0);
    idle(1'b1, 2'd2);
    idle(1'b0, 2'd2);
    // no write-to-read bypass
    cyc(0, 1, 2'd1, 8'h3C, 1, 2'd1, 0, 2'd0, 2'd0, 0, 1'b0, 0);
    idle(1'b1, 2'd1);
    // pair load of pair 1 on consecutive edges, with a PLD restart attempt ignored
    cyc(0, 0, 2'd0, 8'h00, 0, 2'd0, 0, 2'd0, 2'd0, 1, 1'b1, 0);
    cyc(0, 0, 2'd0, 8'h34, 0, 2'd0, 0, 2'd0, 2'd0, 1, 1'b0, 1);
    cyc(0, 1, 2'd0, 8'h12, 1, 2'd3, 0, 2'd0, 2'd0, 0, 1'b0, 1);
    idle(1'b1, 2'd3);
    idle(1'b1, 2'd2);
    // swap with distinct and equal operands
    cyc(0, 1, 2'd0, 8'h11, 0, 2'd0, 0, 2'd0, 2'd0, 0, 1'b0, 0);
    cyc(0, 1, 2'd3, 8'h22, 0, 2'd0, 0, 2'd0, 2'd0, 0, 1'b0, 0);
    cyc(0, 0, 2'd0, 8'h00, 1, 2'd0, 1, 2'd0, 2'd3, 0, 1'b0, 0);
    cyc(0, 0, 2'd0, 8'h00, 1, 2'd0, 1, 2'd1, 2'd1, 0, 1'b0, 0);
    idle(1'b1, 2'd3);
    // swap blocks a capture: strobe lost, sequencer holds
    cyc(0, 0, 2'd0, 8'h00, 0, 2'd0, 0, 2'd0, 2'd0, 1, 1'b0, 0);
    cyc(0, 0, 2'd0, 8'h99, 0, 2'd0, 1, 2'd1, 2'd2, 0, 1'b0, 1);
    cyc(0, 0, 2'd0, 8'h55, 0, 2'd0, 0, 2'd0, 2'd0, 0, 1'b0, 1);
    // async reset while waiting for the high byte, later strobe ignored
    async_reset();
    cyc(0, 0, 2'd0, 8'h77, 1, 2'd1, 0, 2'd0, 2'd0, 0, 1'b0, 1);
    idle(1'b1, 2'd1);
    // clear wins over write, swap and capture
    cyc(0, 1, 2'd1, 8'h66, 0, 2'd0, 0, 2'd0, 2'd0, 0, 1'b0, 0);
    cyc(0, 0, 2'd0, 8'h00, 0, 2'd0, 0, 2'd0, 2'd0, 1, 1'b1, 0);
    cyc(0, 0, 2'd0, 8'h44, 0, 2'd0, 0, 2'd0, 2'd0, 0, 1'b0, 1);
    cyc(1, 1, 2'd2, 8'h88, 0, 2'd0, 1, 2'd1, 2'd3, 0, 1'b0, 1);
    idle(1'b1, 2'd1);
    idle();

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
          2'($urandom_range(0, 3)), 8'($urandom), ($urandom_range(0, 1) == 1),
          2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0));
    end
    idle();

    // final report
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge CLK_I);
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected vectors never checked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
